// File: rtl/perceptron_infer.sv
// ============================================================================
// Module   : perceptron_infer
// Purpose  : Perceptron inference engine. A single valid/ready byte stream
//            carries both signed weight bytes (in_kind = 1) and unsigned
//            feature bytes (in_kind = 0). Each sample's dot product is
//            accumulated serially, one feature per accepted beat. When the
//            last feature of a sample arrives, the class byte (8'hFF when
//            the dot product is strictly positive, else 8'h00) and the raw
//            accumulator are presented on a valid/ready result port.
//
// Optional : PERCEPTRON_BIAS_EN - adds a signed bias weight at index
//            INP_DIM; the accumulator starts every sample from sext(bias).
//
// Parameters:
//   INP_DIM  features per sample / number of weights (1..16)
//   ACC_W    signed accumulator width, >= 17 + clog2(INP_DIM+1)
//            (>= 17 + clog2(INP_DIM+2) with the bias enabled)
//   SCNT_W   width of the wrapping sample counter
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   input byte valid
//   in_ready    out  block can accept an input byte
//   in_kind     in   0 = feature byte (unsigned), 1 = weight byte (signed)
//   in_data     in   8-bit payload
//   out_valid   out  result valid
//   out_ready   in   consumer accepts result
//   out_class   out  8'hFF if acc > 0 else 8'h00
//   out_acc     out  signed dot product of the completed sample
//   sample_cnt  out  count of results handed off (wraps)
//   err         out  sticky protocol error (weight beat mid-sample)
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perceptron_infer #(
  parameter int INP_DIM = 2,
  parameter int ACC_W   = 20,
  parameter int SCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_class,
  output logic [ACC_W-1:0]  out_acc,
  output logic [SCNT_W-1:0] sample_cnt,
  output logic              err
);

  // --------------------------------------------------------------------------
  // Sizing
  // --------------------------------------------------------------------------
`ifdef PERCEPTRON_BIAS_EN
  // One extra weight slot holds the bias.
  localparam int NW = INP_DIM + 1;
`else
  localparam int NW = INP_DIM;
`endif

  localparam int WI_W = (NW > 1)      ? $clog2(NW)      : 1;
  localparam int XI_W = (INP_DIM > 1) ? $clog2(INP_DIM) : 1;

  localparam logic [WI_W-1:0] W_LAST = WI_W'(NW - 1);
  localparam logic [XI_W-1:0] X_LAST = XI_W'(INP_DIM - 1);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                    state_q;
  logic signed [7:0]         w_q [NW];
  logic signed [ACC_W-1:0]   acc_q;
  logic [XI_W-1:0]           x_idx_q;
  logic [WI_W-1:0]           w_idx_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [7:0]                out_class_q;
  logic signed [ACC_W-1:0]   out_acc_q;
  logic [SCNT_W-1:0]         sample_cnt_q;
  logic                      err_q;

  // --------------------------------------------------------------------------
  // Datapath: one multiply-accumulate per accepted feature beat
  // --------------------------------------------------------------------------
  logic signed [7:0]         w_sel;
  logic signed [ACC_W-1:0]   feat_ext;
  logic signed [ACC_W-1:0]   wt_ext;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_reload;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      class_pos;

  always_comb begin
    w_sel    = w_q[WI_W'(x_idx_q)];
    // Feature is unsigned: zero-extend. Weight is two's complement: sign-extend.
    feat_ext = $signed({{(ACC_W-8){1'b0}}, in_data});
    wt_ext   = $signed({{(ACC_W-8){w_sel[7]}}, w_sel});
    term     = feat_ext * wt_ext;

`ifdef PERCEPTRON_BIAS_EN
    acc_reload = $signed({{(ACC_W-8){w_q[NW-1][7]}}, w_q[NW-1]});
    // At the first feature of a sample, start from the current bias so a
    // bias rewritten between samples takes effect immediately.
    acc_base   = (x_idx_q == '0) ? acc_reload : acc_q;
`else
    acc_reload = '0;
    acc_base   = acc_q;
`endif

    acc_d     = acc_base + term;
    // Strictly greater than zero: sign bit clear and not all-zero.
    class_pos = !acc_d[ACC_W-1] && (acc_d != '0);
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_ACC;
      for (int i = 0; i < NW; i++) begin
        w_q[i] <= '0;
      end
      acc_q        <= '0;
      x_idx_q      <= '0;
      w_idx_q      <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_class_q  <= 8'h00;
      out_acc_q    <= '0;
      sample_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (in_valid && in_ready_q) begin
            if (in_kind) begin
              // Weights may only be loaded between samples; a weight beat
              // mid-sample is dropped and flagged.
              if (x_idx_q == '0) begin
                w_q[w_idx_q] <= $signed(in_data);
                w_idx_q      <= (w_idx_q == W_LAST) ? '0 : w_idx_q + 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else if (x_idx_q == X_LAST) begin
              out_acc_q   <= acc_d;
              out_class_q <= class_pos ? 8'hFF : 8'h00;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              acc_q       <= acc_reload;
              x_idx_q     <= '0;
              state_q     <= S_OUT;
            end else begin
              acc_q   <= acc_d;
              x_idx_q <= x_idx_q + 1'b1;
            end
          end
        end

        S_OUT: begin
          // Input is stalled and the result held until the consumer takes it.
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            sample_cnt_q <= sample_cnt_q + 1'b1;
            in_ready_q   <= 1'b1;
            state_q      <= S_ACC;
          end
        end

        default: begin
          state_q <= S_ACC;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_acc    = out_acc_q;
  assign sample_cnt = sample_cnt_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_infer.sv
// ============================================================================
// Module   : tb_perceptron_infer
// Purpose  : Directed self-checking bench for perceptron_infer with the
//            default parameters (INP_DIM = 2, ACC_W = 20, SCNT_W = 8).
//            Expected values are hand-computed dot products.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perceptron_infer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_kind = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_class;
  logic [19:0] out_acc;
  logic [7:0]  sample_cnt;
  logic        err;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  perceptron_infer #(
    .INP_DIM (2),
    .ACC_W   (20),
    .SCNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_acc    (out_acc),
    .sample_cnt (sample_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic k, input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_kind  = k;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: observed in_ready=0, expected 1 within 50 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_w(input logic [7:0] a, input logic [7:0] b);
    send(1'b1, a);
    send(1'b1, b);
`ifdef PERCEPTRON_BIAS_EN
    send(1'b1, 8'h00);
`endif
  endtask

  task automatic sample(input logic [7:0] f0, input logic [7:0] f1);
    send(1'b0, f0);
    chk("no_result_mid_sample", 32'(out_valid), 0);
    send(1'b0, f1);
  endtask

  task automatic check_result(input string tag, input logic signed [31:0] acc,
                              input logic [7:0] cls);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_acc"}, $signed(out_acc), acc);
    chk({tag, "_class"}, 32'(out_class), 32'(cls));
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk("handoff_cnt", 32'(sample_cnt), exp_cnt);
    chk("handoff_valid_low", 32'(out_valid), 0);
    chk("handoff_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_out_acc", $signed(out_acc), 0);
    chk("rst_sample_cnt", 32'(sample_cnt), 0);
    chk("rst_err", 32'(err), 0);

    // Basic classify: 2*4 + 3*9 = 35
    load_w(8'd4, 8'd9);
    sample(8'd2, 8'd3);
    check_result("basic", 35, 8'hFF);
    chk("basic_in_ready_low", 32'(in_ready), 0);
    take();

    // Negative: 4*-5 + 5*1 = -15 ; 1*-5 + 5*1 = 0 (strict compare)
    load_w(8'hFB, 8'd1);
    sample(8'd4, 8'd5);
    check_result("neg", -15, 8'h00);
    take();
    sample(8'd1, 8'd5);
    check_result("zero", 0, 8'h00);
    take();

    // Backpressure with a feature waiting on the input
    sample(8'd4, 8'd5);
    in_valid = 1'b1;
    in_kind  = 1'b0;
    in_data  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      check_result("bp_hold", -15, 8'h00);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk("bp_handoff_valid", 32'(out_valid), 0);
    chk("bp_handoff_ready", 32'(in_ready), 1);
    chk("bp_handoff_cnt", 32'(sample_cnt), exp_cnt);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_first_feat_only", 32'(out_valid), 0);
    send(1'b0, 8'd1);
    // 7*-5 + 1*1 = -34
    check_result("bp_next", -34, 8'h00);
    take();

    // Extremes
    load_w(8'h80, 8'h80);
    sample(8'd255, 8'd255);
    check_result("min", -65280, 8'h00);
    take();
    load_w(8'h7F, 8'h7F);
    sample(8'd255, 8'd255);
    check_result("max", 64770, 8'hFF);
    take();

    // Protocol error: weight beat mid-sample is dropped
    send(1'b0, 8'd2);
    chk("err_before", 32'(err), 0);
    send(1'b1, 8'd7);
    chk("err_set", 32'(err), 1);
    send(1'b0, 8'd3);
    // 2*127 + 3*127 = 635 with the old weights
    check_result("err_oldw", 635, 8'hFF);
    chk("err_sticky", 32'(err), 1);
    take();

    // Reset mid-sample clears everything
    send(1'b0, 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    chk("mrst_err", 32'(err), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_cnt", 32'(sample_cnt), 0);
    sample(8'd9, 8'd9);
    check_result("mrst_wclr", 0, 8'h00);
    take();
    load_w(8'd0, 8'd0);
    chk("mrst_no_err", 32'(err), 0);
    sample(8'd9, 8'd9);
    check_result("mrst_w0", 0, 8'h00);
    take();

`ifdef PERCEPTRON_BIAS_EN
    // Bias: 2*4 + 3*9 - 36 = -1, twice to confirm the bias reload
    send(1'b1, 8'd4);
    send(1'b1, 8'd9);
    send(1'b1, 8'hDC);
    sample(8'd2, 8'd3);
    check_result("bias1", -1, 8'h00);
    take();
    sample(8'd2, 8'd3);
    check_result("bias2", -1, 8'h00);
    take();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/perceptron_infer.md
Name: perceptron_infer

Overview:
- Inference-side counterpart to the perceptron trainer: reads a trained weight vector and classifies streamed samples.
- Weights and feature bytes arrive on one valid/ready byte stream, tagged by in_kind.
- Each sample's dot product is accumulated serially, one feature per accepted beat.
- Each completed sample emits a class byte (8'hFF / 8'h00) and the raw accumulator on a valid/ready result port, for uo_out and for debug.

Parameters:
- INP_DIM, 2, features per sample and number of weights; range 1..16.
- ACC_W, 20, signed accumulator width; must satisfy ACC_W >= 17 + clog2(INP_DIM+1).
- SCNT_W, 8, width of the sample counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  block can accept an input byte
- in_kind  in  1  0 = feature byte (unsigned), 1 = weight byte (signed two's complement)
- in_data  in  8  payload
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  8  8'hFF if acc > 0, else 8'h00
- out_acc  out  ACC_W  signed dot product of completed sample
- sample_cnt  out  SCNT_W  count of results handed off; wraps
- err  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous, active-low, sampled on posedge clk.
- Reset values: state = S_ACC, all W[i] = 0, acc = 0, x_idx = 0, w_idx = 0, out_valid = 0, out_class = 8'h00, out_acc = 0, sample_cnt = 0, err = 0, in_ready = 1 in the cycle after reset release.
- Reset mid-sample or with a result pending discards everything; a pending out_valid drops.
- Beat accept = in_valid & in_ready. Result handoff = out_valid & out_ready.
- State S_ACC:
  - in_ready = 1.
  - Weight beat with x_idx == 0: W[w_idx] <= in_data; w_idx increments, wrapping INP_DIM-1 -> 0.
  - Weight beat with x_idx != 0: byte dropped, W and w_idx unchanged, err <= 1.
  - Feature beat, not last (x_idx < INP_DIM-1): acc <= acc + zext(in_data) * sext(W[x_idx]), computed at ACC_W signed; x_idx++.
  - Feature beat, last (x_idx == INP_DIM-1): out_acc <= acc + term; out_class <= (acc + term > 0) ? 8'hFF : 8'h00; out_valid <= 1; acc <= 0; x_idx <= 0; go to S_OUT.
- State S_OUT:
  - in_ready = 0; out_valid = 1; out_acc and out_class held stable.
  - On handoff: out_valid <= 0, sample_cnt++, return to S_ACC; in_ready = 1 from the next cycle.
- Latency: out_valid is high the cycle after the last feature beat is accepted. Minimum throughput is one sample per INP_DIM+1 cycles with out_ready held high.
- Comparison is strict signed > 0; acc == 0 gives class 8'h00.
- No overflow is possible under the ACC_W constraint; no saturation logic.
- Weights persist across samples until overwritten or reset.
- in_data and in_kind are ignored when in_valid = 0.
- err clears only on reset.

Optional Feature:
- Macro: PERCEPTRON_BIAS_EN.
- Defined:
  - Weight index INP_DIM holds a signed bias B; w_idx wraps INP_DIM -> 0, giving INP_DIM+1 weight slots.
  - At the start of each sample, and after reset, acc initialises to sext(B) instead of 0; after each completed sample, acc <= sext(B).
  - The ACC_W constraint becomes ACC_W >= 17 + clog2(INP_DIM+2).
- Undefined: no bias register; w_idx wraps at INP_DIM-1; acc initialises to 0.

Test Plan:
- Basic classify: reset; weights 8'd4, 8'd9; features 2, 3 -> out_acc = 35, out_class = 8'hFF, out_valid one cycle after the 2nd feature, sample_cnt = 1 after handoff.
- Negative result: weights 8'hFB (-5), 8'd1; features 4, 5 -> out_acc = -15, out_class = 8'h00. Features 1, 5 -> out_acc = 0, out_class = 8'h00 (strict compare).
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0 and out_* stable throughout. Raise out_ready -> exactly one handoff, in_ready = 1 next cycle, the next feature is accepted.
- Extremes: weights 8'h80 (-128) twice; features 255, 255 -> out_acc = -65280, class 8'h00. Weights 8'h7F twice -> out_acc = 64770, class 8'hFF.
- Protocol error and reset: feature 2, then a weight beat 8'd7 -> err = 1, W unchanged; feature 3 completes with the old weights. Then feature 1 followed by rst_n low for 1 cycle -> x_idx, acc, W, err all cleared; weights 0, features 9, 9 -> out_acc = 0, class 8'h00.
- With PERCEPTRON_BIAS_EN: weights 4, 9, bias 8'hDC (-36); features 2, 3 -> out_acc = -1, class 8'h00. Next sample with features 2, 3 again gives the same result, confirming the bias reload.
